// File: rtl/onchip_mem_arbiter_if.sv
// Avalon-MM master-side bundle for one requester of the shared on-chip RAM.
// The master drives the request fields and the arbiter drives the responses.
interface onchip_mem_arbiter_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   address;
  logic [DATA_W/8-1:0] byteenable;
  logic                read;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic                lock;
  logic                waitrequest;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;

  modport master (
    output address, byteenable, read, write, writedata, lock,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, byteenable, read, write, writedata, lock,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/onchip_mem_arbiter.sv
// Two-master round-robin arbiter with bounded lock in front of a single-port RAM.
// Grant is combinational; read data returns one cycle after an accepted read.
module onchip_mem_arbiter #(
  parameter int ADDR_W   = 15,
  parameter int DATA_W   = 32,
  parameter int MAX_LOCK = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  onchip_mem_arbiter_if.slave   m0,
  onchip_mem_arbiter_if.slave   m1,
  output logic [ADDR_W-1:0]     mem_address,
  output logic [DATA_W/8-1:0]   mem_byteenable,
  output logic                  mem_chipselect,
  output logic                  mem_write,
  output logic [DATA_W-1:0]     mem_writedata,
  output logic                  mem_clken,
  input  logic [DATA_W-1:0]     mem_readdata
);
  localparam int CNT_W = $clog2(MAX_LOCK + 1);
  localparam logic [CNT_W-1:0] LOCK_MAX = CNT_W'(MAX_LOCK);

  logic [1:0]       rst_sync_q, rst_sync_d;
  logic             rr_ptr_q, rr_ptr_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
  logic             rd_pend_q, rd_pend_d;
  logic             owner_q, owner_d;

  logic rst_ok, req0, req1, both, act, last_lock, win, win_rd, win_wr;

  // State registers; rst_sync_q makes reset release synchronous to clk.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rst_sync_q <= 2'b00;
      rr_ptr_q   <= 1'b0;
      last_q     <= 1'b0;
      lock_cnt_q <= '0;
      rd_pend_q  <= 1'b0;
      owner_q    <= 1'b0;
    end else begin
      rst_sync_q <= rst_sync_d;
      rr_ptr_q   <= rr_ptr_d;
      last_q     <= last_d;
      lock_cnt_q <= lock_cnt_d;
      rd_pend_q  <= rd_pend_d;
      owner_q    <= owner_d;
    end
  end

  // Grant decision: a locked last winner keeps priority until LOCK_MAX contested grants.
  always_comb begin
    rst_ok    = rst_sync_q[1];
    req0      = m0.read | m0.write;
    req1      = m1.read | m1.write;
    both      = req0 & req1;
    act       = rst_ok & (req0 | req1);
    last_lock = last_q ? m1.lock : m0.lock;
    if (both) begin
      if (last_lock && (lock_cnt_q < LOCK_MAX)) begin
        win = last_q;
      end else begin
        win = rr_ptr_q;
      end
    end else if (req1) begin
      win = 1'b1;
    end else begin
      win = 1'b0;
    end
    win_wr = win ? m1.write : m0.write;
    win_rd = win ? m1.read  : m0.read;
  end

  // Next-state; the lock counter only advances while both masters contend.
  always_comb begin
    rst_sync_d = {rst_sync_q[0], 1'b1};
    rr_ptr_d   = rr_ptr_q;
    last_d     = last_q;
    lock_cnt_d = lock_cnt_q;
    rd_pend_d  = 1'b0;
    owner_d    = owner_q;
    if (act) begin
      rr_ptr_d  = ~win;
      last_d    = win;
      owner_d   = win;
      rd_pend_d = win_rd & ~win_wr;
      if (both) begin
        if ((win == last_q) && last_lock) begin
          lock_cnt_d = (lock_cnt_q == LOCK_MAX) ? lock_cnt_q : lock_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          lock_cnt_d = '0;
        end
      end else if (win == last_q) begin
        lock_cnt_d = lock_cnt_q;
      end else begin
        lock_cnt_d = '0;
      end
    end else begin
      rd_pend_d = 1'b0;
    end
  end

  // Outputs: winner muxed onto the RAM port, read data steered to the owner.
  always_comb begin
    mem_clken      = rst_ok;
    mem_chipselect = act;
    mem_write      = act & win_wr;
    if (win) begin
      mem_address    = m1.address;
      mem_byteenable = m1.byteenable;
      mem_writedata  = m1.writedata;
    end else begin
      mem_address    = m0.address;
      mem_byteenable = m0.byteenable;
      mem_writedata  = m0.writedata;
    end
    m0.waitrequest   = ~(act & ~win);
    m1.waitrequest   = ~(act & win);
    m0.readdatavalid = rd_pend_q & ~owner_q;
    m1.readdatavalid = rd_pend_q & owner_q;
    m0.readdata      = mem_readdata;
    m1.readdata      = mem_readdata;
  end
endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Scoreboard bench for onchip_mem_arbiter: per-master command queues, a reference
// memory for expected read data, and expected-grant queues for arbitration order.
module tb_onchip_mem_arbiter;
  localparam int AW = 15;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  onchip_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m0_if();
  onchip_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m1_if();

  logic [AW-1:0] mem_address;
  logic [3:0]    mem_byteenable;
  logic          mem_chipselect, mem_write, mem_clken;
  logic [31:0]   mem_writedata;
  logic [31:0]   mem_readdata = 32'h0;

  onchip_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_LOCK(8)) dut (
    .clk(clk), .reset_n(reset_n), .m0(m0_if), .m1(m1_if),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata)
  );

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
    for (int b = 0; b < 4; b++) if (be[b]) o[8*b +: 8] = n[8*b +: 8];
    return o;
  endfunction

  // Single-port RAM with one-cycle read latency.
  logic [31:0] ram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_clken && mem_chipselect) begin
      if (mem_write) ram[mem_address] <= merge(ram[mem_address], mem_writedata, mem_byteenable);
      else           mem_readdata <= ram[mem_address];
    end
  end

  typedef struct {
    bit          rd;
    bit          wr;
    logic [AW-1:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
    bit          lock;
  } cmd_t;

  cmd_t        cq0[$], cq1[$];
  logic [31:0] rq0[$], rq1[$];
  int          gq[$];
  bit          pend0, pend1;
  logic [31:0] ref_mem [int];
  logic [31:0] last_rd0, last_rd1;
  int          checks = 0;
  int          errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 32'h0;
  endfunction

  task automatic push(input int m, input bit rd, input bit wr, input logic [AW-1:0] a,
                      input logic [3:0] be, input logic [31:0] d, input bit lk);
    cmd_t c;
    c.rd = rd; c.wr = wr; c.addr = a; c.be = be; c.data = d; c.lock = lk;
    if (m == 0) cq0.push_back(c);
    else        cq1.push_back(c);
  endtask

  task automatic drive();
    if (cq0.size() > 0) begin
      m0_if.read = cq0[0].rd; m0_if.write = cq0[0].wr; m0_if.address = cq0[0].addr;
      m0_if.byteenable = cq0[0].be; m0_if.writedata = cq0[0].data; m0_if.lock = cq0[0].lock;
    end else begin
      m0_if.read = 1'b0; m0_if.write = 1'b0; m0_if.address = '0;
      m0_if.byteenable = 4'h0; m0_if.writedata = 32'h0; m0_if.lock = 1'b0;
    end
    if (cq1.size() > 0) begin
      m1_if.read = cq1[0].rd; m1_if.write = cq1[0].wr; m1_if.address = cq1[0].addr;
      m1_if.byteenable = cq1[0].be; m1_if.writedata = cq1[0].data; m1_if.lock = cq1[0].lock;
    end else begin
      m1_if.read = 1'b0; m1_if.write = 1'b0; m1_if.address = '0;
      m1_if.byteenable = 4'h0; m1_if.writedata = 32'h0; m1_if.lock = 1'b0;
    end
  endtask

  task automatic accept(input int m, input cmd_t c);
    if (c.wr) begin
      ref_mem[int'(c.addr)] = merge(ref_rd(c.addr), c.data, c.be);
    end else if (m == 0) begin
      rq0.push_back(ref_rd(c.addr)); pend0 = 1'b1;
    end else begin
      rq1.push_back(ref_rd(c.addr)); pend1 = 1'b1;
    end
  endtask

  task automatic cycle();
    bit g0, g1, act;
    logic [31:0] e;
    @(negedge clk);
    drive();
    #1;
    check_eq("rdv0", m0_if.readdatavalid, pend0);
    check_eq("rdv1", m1_if.readdatavalid, pend1);
    if (pend0) begin
      e = rq0.pop_front(); last_rd0 = m0_if.readdata; check_eq("rdata0", m0_if.readdata, e);
    end
    if (pend1) begin
      e = rq1.pop_front(); last_rd1 = m1_if.readdata; check_eq("rdata1", m1_if.readdata, e);
    end
    pend0 = 1'b0; pend1 = 1'b0;
    act = (cq0.size() > 0) || (cq1.size() > 0);
    g0  = !m0_if.waitrequest;
    g1  = !m1_if.waitrequest;
    check_eq("chipselect", mem_chipselect, act);
    check_eq("ngrant", 32'(g0) + 32'(g1), 32'(act));
    if (act && gq.size() > 0) check_eq("grant", g1 ? 32'd1 : 32'd0, gq.pop_front());
    if (g0 && cq0.size() > 0) accept(0, cq0.pop_front());
    if (g1 && cq1.size() > 0) accept(1, cq1.pop_front());
  endtask

  task automatic run(input int max);
    int n = 0;
    while ((cq0.size() > 0 || cq1.size() > 0 || pend0 || pend1) && n < max) begin
      cycle();
      n++;
    end
    if (n >= max) check_eq("timeout_left", cq0.size() + cq1.size(), 0);
    check_eq("grants_left", gq.size(), 0);
    gq.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_wait0"}, m0_if.waitrequest, 1'b1);
    check_eq({tag, "_wait1"}, m1_if.waitrequest, 1'b1);
    check_eq({tag, "_rdv0"}, m0_if.readdatavalid, 1'b0);
    check_eq({tag, "_rdv1"}, m1_if.readdatavalid, 1'b0);
    check_eq({tag, "_cs"}, mem_chipselect, 1'b0);
    check_eq({tag, "_clken"}, mem_clken, 1'b0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_eq("clken_after_release", mem_clken, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    pend0 = 1'b0; pend1 = 1'b0;
    drive();
    @(negedge clk); #1;
    check_reset_outputs("por");
    release_reset();

    // Write then cross-master read of the same word.
    push(0, 1'b0, 1'b1, 15'h0010, 4'hF, 32'hDEADBEEF, 1'b0);
    run(10);
    push(1, 1'b1, 1'b0, 15'h0010, 4'hF, 32'h0, 1'b0);
    run(10);
    check_eq("t2_data", last_rd1, 32'hDEADBEEF);

    // Write from m0 and read from m1 in consecutive cycles.
    push(0, 1'b0, 1'b1, 15'h0020, 4'hF, 32'h5A5A1234, 1'b0);
    push(1, 1'b1, 1'b0, 15'h0020, 4'hF, 32'h0, 1'b0);
    gq = '{0, 1};
    run(10);
    check_eq("rdw_data", last_rd1, 32'h5A5A1234);

    // Partial byte write at the top address.
    push(0, 1'b0, 1'b1, 15'h7FFF, 4'hF, 32'h11223344, 1'b0);
    push(0, 1'b0, 1'b1, 15'h7FFF, 4'b0010, 32'h0000AB00, 1'b0);
    push(0, 1'b1, 1'b0, 15'h7FFF, 4'hF, 32'h0, 1'b0);
    run(10);
    check_eq("t5_data", last_rd0, 32'h1122AB44);

    // Read and write together: write wins, no read response.
    push(0, 1'b1, 1'b1, 15'h0030, 4'hF, 32'hCAFEF00D, 1'b0);
    run(10);
    push(1, 1'b1, 1'b0, 15'h0030, 4'hF, 32'h0, 1'b0);
    run(10);
    check_eq("t6_data", last_rd1, 32'hCAFEF00D);

    // Reset while reads are in flight.
    for (int i = 0; i < 6; i++) begin
      push(0, 1'b1, 1'b0, 15'h0010, 4'hF, 32'h0, 1'b0);
      push(1, 1'b1, 1'b0, 15'h7FFF, 4'hF, 32'h0, 1'b0);
    end
    repeat (3) cycle();
    #1 reset_n = 1'b0;
    #1 check_reset_outputs("mid");
    @(posedge clk); #1;
    check_eq("mid_rdv0_next", m0_if.readdatavalid, 1'b0);
    check_eq("mid_rdv1_next", m1_if.readdatavalid, 1'b0);
    cq0.delete(); cq1.delete(); rq0.delete(); rq1.delete();
    pend0 = 1'b0; pend1 = 1'b0;
    drive();
    release_reset();

    // First tie after reset goes to m0.
    push(0, 1'b1, 1'b0, 15'h0010, 4'hF, 32'h0, 1'b0);
    push(1, 1'b1, 1'b0, 15'h0020, 4'hF, 32'h0, 1'b0);
    gq = '{0, 1};
    run(10);

    // Continuous reads from both masters alternate.
    for (int i = 0; i < 4; i++) begin
      push(0, 1'b1, 1'b0, (i % 2 == 0) ? 15'h0010 : 15'h7FFF, 4'hF, 32'h0, 1'b0);
      push(1, 1'b1, 1'b0, (i % 2 == 0) ? 15'h0030 : 15'h0020, 4'hF, 32'h0, 1'b0);
      gq.push_back(0);
      gq.push_back(1);
    end
    run(30);

    // m1 locked: eight contested grants, one to m0, then m1 resumes.
    push(1, 1'b1, 1'b0, 15'h0010, 4'hF, 32'h0, 1'b1);
    push(1, 1'b1, 1'b0, 15'h0020, 4'hF, 32'h0, 1'b1);
    run(10);
    for (int i = 0; i < 12; i++) push(1, 1'b1, 1'b0, (i % 2 == 0) ? 15'h0030 : 15'h7FFF, 4'hF, 32'h0, 1'b1);
    push(0, 1'b1, 1'b0, 15'h0010, 4'hF, 32'h0, 1'b0);
    push(0, 1'b1, 1'b0, 15'h0020, 4'hF, 32'h0, 1'b0);
    for (int i = 0; i < 8; i++) gq.push_back(1);
    gq.push_back(0);
    for (int i = 0; i < 4; i++) gq.push_back(1);
    gq.push_back(0);
    run(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
